// File: rtl/dma_io_requester_pkg.sv
// Shared types for the peripheral side of the DREQ/DACK handshake.
package dma_io_requester_pkg;

    typedef enum logic {
        DMA_WRITE = 1'b0,   // I/O -> memory, device drives DB on IOR
        DMA_READ  = 1'b1    // memory -> I/O, device captures DB on IOW
    } DMA_READ_WRITE_e;

    typedef enum logic [3:0] {
        DEV_IDLE = 4'b0001,
        DEV_REQ  = 4'b0010,
        DEV_ACK  = 4'b0100,
        DEV_DONE = 4'b1000
    } DEV_STATE_e;

endpackage

// File: rtl/dma_io_requester_fifo.sv
// Byte FIFO between the DMA bus and the local stream; push and pop may share a cycle.
module dma_dev_fifo #(
    parameter int DEPTH = 8,
    parameter int DW    = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [DW-1:0]            wdata_i,
    input  logic                     pop_i,
    output logic [DW-1:0]            rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // Push into a full FIFO is refused even if a pop lands in the same cycle.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/dma_io_requester.sv
// DMA-capable I/O device: buffers bytes and answers the controller's DREQ/DACK/IOR/IOW cycles.
module dma_io_requester
    import dma_io_requester_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int DW    = 8
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          enable,
    input  logic          dir,
    input  logic          demand,
    input  logic          dreq_active_low,
    input  logic          dack_active_low,
    output logic          DREQ,
    input  logic          DACK,
    input  logic          IOR_N,
    input  logic          IOW_N,
    input  logic          EOP_N,
    input  logic [DW-1:0] db_in,
    output logic [DW-1:0] db_out,
    output logic          db_oe,
    input  logic          src_valid,
    output logic          src_ready,
    input  logic [DW-1:0] src_data,
    output logic          snk_valid,
    input  logic          snk_ready,
    output logic [DW-1:0] snk_data,
    output logic          tc_seen,
    output logic          xfer_err
);
    localparam int CW = $clog2(DEPTH) + 1;

    DEV_STATE_e      state_q, state_d;
    DMA_READ_WRITE_e dir_q, dir_d, dir_eff;
    logic            demand_q, demand_d;
    logic            dreq_q, dreq_d;
    logic            ior_act_q, iow_act_q, eop_q, eop_d, err_q, err_d;
    logic [DW-1:0]   data_q, data_d;

    logic            dack_act, xfer_en, dbl, ior_strobe, iow_strobe;
    logic            rd_done, wr_done, xfer_done;
    logic            src_push, snk_pop, dma_push, dma_pop;
    logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [DW-1:0]   fifo_wdata, fifo_rdata;
    logic [CW-1:0]   fifo_count, count_nxt;

    function automatic logic req_ok(input DMA_READ_WRITE_e d, input logic [CW-1:0] c);
        return (d == DMA_WRITE) ? (c != '0) : (c < CW'(DEPTH));
    endfunction

    // Direction follows the live input while idle so the local side can prefill.
    assign dir_eff  = (state_q == DEV_IDLE) ? DMA_READ_WRITE_e'(dir) : dir_q;
    assign dack_act = DACK ^ dack_active_low;
    assign xfer_en  = dack_act && (state_q != DEV_DONE);
    assign dbl      = xfer_en && !IOR_N && !IOW_N;

    // Read strobes drive the bus only while granted; a late write strobe after
    // DREQ dropped is still accounted so a full FIFO shows up as an overrun.
    assign ior_strobe = dack_act && (state_q == DEV_ACK) && (dir_eff == DMA_WRITE) && !IOR_N && IOW_N;
    assign iow_strobe = xfer_en && (dir_eff == DMA_READ) && !IOW_N && IOR_N;
    assign rd_done    = ior_act_q && IOR_N;
    assign wr_done    = iow_act_q && IOW_N;
    assign xfer_done  = (dir_q == DMA_WRITE) ? rd_done : wr_done;

    assign eop_d  = (ior_strobe || iow_strobe) ? (eop_q || !EOP_N) : 1'b0;
    assign data_d = iow_strobe ? db_in : data_q;

    assign src_ready = !fifo_full && (dir_eff == DMA_WRITE);
    assign snk_valid = !fifo_empty && (dir_eff == DMA_READ);
    assign snk_data  = fifo_rdata;
    assign src_push  = src_valid && src_ready;
    assign snk_pop   = snk_valid && snk_ready;
    assign dma_push  = wr_done && !fifo_full;
    assign dma_pop   = rd_done && !fifo_empty;

    assign fifo_push  = dma_push || src_push;
    assign fifo_wdata = dma_push ? data_q : src_data;
    assign fifo_pop   = dma_pop || snk_pop;
    assign count_nxt  = fifo_count + CW'(fifo_push) - CW'(fifo_pop);

    assign err_d = err_q || dbl || (rd_done && fifo_empty) || (wr_done && fifo_full);

    always_comb begin
        state_d  = state_q;
        dir_d    = dir_q;
        demand_d = demand_q;
        unique case (state_q)
            DEV_IDLE: begin
                if (enable && req_ok(dir_eff, fifo_count)) begin
                    state_d  = DEV_REQ;
                    dir_d    = dir_eff;
                    demand_d = demand;
                end
            end
            // Enable is ignored here: the controller expects DREQ held until DACK.
            DEV_REQ: if (dack_act) state_d = DEV_ACK;
            DEV_ACK: begin
                if (xfer_done) begin
                    if (eop_q)                                  state_d = DEV_DONE;
                    else if (demand_q && req_ok(dir_q, count_nxt)) state_d = DEV_ACK;
                    else                                        state_d = DEV_IDLE;
                end else if (!dack_act && !ior_act_q && !iow_act_q) begin
                    state_d = DEV_IDLE;
                end
            end
            DEV_DONE: if (!enable) state_d = DEV_IDLE;
            default:  state_d = DEV_IDLE;
        endcase
        dreq_d = (state_d == DEV_REQ) || (state_d == DEV_ACK);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= DEV_IDLE;
            dir_q     <= DMA_WRITE;
            demand_q  <= 1'b0;
            dreq_q    <= 1'b0;
            ior_act_q <= 1'b0;
            iow_act_q <= 1'b0;
            eop_q     <= 1'b0;
            err_q     <= 1'b0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            demand_q  <= demand_d;
            dreq_q    <= dreq_d;
            ior_act_q <= ior_strobe;
            iow_act_q <= iow_strobe;
            eop_q     <= eop_d;
            err_q     <= err_d;
            data_q    <= data_d;
        end
    end

    dma_dev_fifo #(.DEPTH(DEPTH), .DW(DW)) u_fifo (
        .clk_i   (CLK),
        .rst_i   (RESET),
        .push_i  (fifo_push),
        .wdata_i (fifo_wdata),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign DREQ     = dreq_q ^ dreq_active_low;
    assign db_oe    = ior_strobe;
    assign db_out   = (ior_strobe && !fifo_empty) ? fifo_rdata : '0;
    assign tc_seen  = (state_q == DEV_DONE);
    assign xfer_err = err_q;

endmodule
